// File: rtl/div_hs_param.sv
// Iterative restoring divider (one quotient bit per clock) behind a four-phase REQ/ACK handshake.
// Define DIV_OVF_EN to add the OVF port flagging signed MIN / -1.
module div_hs_param #(
  parameter int W  = 16,
  parameter int CW = $clog2(W + 1)
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ,
  input  logic         SGN,
  input  logic [W-1:0] A,
  input  logic [W-1:0] D,
  output logic         ACK,
  output logic [W-1:0] Q,
  output logic [W-1:0] R,
  output logic         FDBZ
`ifdef DIV_OVF_EN
  ,
  output logic         OVF
`endif
);

  // Handshake: REQ rises with operands stable; ACK rises with a registered
  // result; REQ falls; ACK falls; only then may a new REQ be accepted.
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           neg_q, neg_d;
  logic           a_neg_q, a_neg_d;
  logic [W-1:0]   d_mag_q, d_mag_d;
  logic [W-1:0]   rem_q, rem_d;
  logic [W-1:0]   quo_q, quo_d;
  logic           dbz_q, dbz_d;
  logic           ack_q, ack_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   r_q, r_d;
  logic           fdbz_q, fdbz_d;
`ifdef DIV_OVF_EN
  logic           ovf_cap_q, ovf_cap_d;
  logic           ovf_q, ovf_d;
`endif

  logic           a_neg, d_neg;
  logic [W-1:0]   a_mag, d_mag;
  logic [W:0]     sh;
  logic           take;
  logic [W-1:0]   rem_sub;
  logic [W-1:0]   q_res, r_res;
  logic           load_res;

  always_comb begin
    a_neg = SGN & A[W-1];
    d_neg = SGN & D[W-1];
    a_mag = a_neg ? -A : A;
    d_mag = d_neg ? -D : D;
    // Partial remainder stays below the divisor, so the W-bit difference is exact.
    sh      = {rem_q, quo_q[W-1]};
    take    = (sh >= {1'b0, d_mag_q});
    rem_sub = sh[W-1:0] - d_mag_q;
    q_res   = neg_q ? -quo_q : quo_q;
    r_res   = a_neg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    d_mag_d  = d_mag_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dbz_d    = dbz_q;
    ack_d    = ack_q;
    q_d      = q_q;
    r_d      = r_q;
    fdbz_d   = fdbz_q;
    load_res = 1'b0;
`ifdef DIV_OVF_EN
    ovf_cap_d = ovf_cap_q;
    ovf_d     = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        ack_d = 1'b0;
        if (REQ) begin
          neg_d   = SGN & (A[W-1] ^ D[W-1]);
          a_neg_d = a_neg;
          d_mag_d = d_mag;
          dbz_d   = (D == '0);
`ifdef DIV_OVF_EN
          ovf_cap_d = SGN && (A == MIN_V) && (D == '1);
`endif
          if (D == '0) begin
            // Divide by zero: remainder path reproduces the raw dividend, quotient 0.
            rem_d   = a_mag;
            quo_d   = '0;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            cnt_d   = CW'(W);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = take ? rem_sub : sh[W-1:0];
        quo_d = {quo_q[W-2:0], take};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        load_res = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        // ACK still low here only when arriving straight from a divide-by-zero capture.
        if (!ack_q) begin
          load_res = 1'b1;
        end else if (!REQ) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_res) begin
      q_d    = q_res;
      r_d    = r_res;
      fdbz_d = dbz_q;
      ack_d  = 1'b1;
`ifdef DIV_OVF_EN
      ovf_d  = ovf_cap_q;
`endif
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      a_neg_q <= 1'b0;
      d_mag_q <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dbz_q   <= 1'b0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      fdbz_q  <= 1'b0;
`ifdef DIV_OVF_EN
      ovf_cap_q <= 1'b0;
      ovf_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      a_neg_q <= a_neg_d;
      d_mag_q <= d_mag_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dbz_q   <= dbz_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      r_q     <= r_d;
      fdbz_q  <= fdbz_d;
`ifdef DIV_OVF_EN
      ovf_cap_q <= ovf_cap_d;
      ovf_q     <= ovf_d;
`endif
    end
  end

  assign ACK  = ack_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign FDBZ = fdbz_q;
`ifdef DIV_OVF_EN
  assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_div_hs_param.sv
// Directed and random bench for div_hs_param: W=16 instance with a result scoreboard,
// plus a W=8 instance for the narrow signed case.
module tb_div_hs_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ, SGN;
  logic [15:0] A, D;
  logic        ACK;
  logic [15:0] Q, R;
  logic        FDBZ;
  logic        REQ8, SGN8;
  logic [7:0]  A8, D8;
  logic        ACK8;
  logic [7:0]  Q8, R8;
  logic        FDBZ8;
`ifdef DIV_OVF_EN
  logic        OVF, OVF8;
`endif

  int errors = 0;
  int checks = 0;

  // {fdbz, ovf, q, r}
  logic [33:0] exp_q[$];

  div_hs_param #(.W(16)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .SGN(SGN), .A(A), .D(D),
    .ACK(ACK), .Q(Q), .R(R), .FDBZ(FDBZ)
`ifdef DIV_OVF_EN
    , .OVF(OVF)
`endif
  );

  div_hs_param #(.W(8)) dut8 (
    .CLK(CLK), .RST(RST), .REQ(REQ8), .SGN(SGN8), .A(A8), .D(D8),
    .ACK(ACK8), .Q(Q8), .R(R8), .FDBZ(FDBZ8)
`ifdef DIV_OVF_EN
    , .OVF(OVF8)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: truncating division via the simulator's signed arithmetic.
  function automatic logic [33:0] model(input logic sgn, input logic [15:0] a, input logic [15:0] d);
    int sa, sd, sq, sr;
    if (d == 16'h0) return {1'b1, 1'b0, 16'h0, a};
    if (sgn) begin
      if (a == 16'h8000 && d == 16'hFFFF) return {1'b0, 1'b1, 16'h8000, 16'h0};
      sa = $signed(a);
      sd = $signed(d);
      sq = sa / sd;
      sr = sa % sd;
      return {1'b0, 1'b0, sq[15:0], sr[15:0]};
    end
    return {1'b0, 1'b0, a / d, a % d};
  endfunction

  task automatic issue(input logic sgn, input logic [15:0] a, input logic [15:0] d,
                       input logic [33:0] expv);
    @(negedge CLK);
    SGN = sgn; A = a; D = d; REQ = 1'b1;
    exp_q.push_back(expv);
  endtask

  // First posedge is the capture edge; counts edges until ACK, then releases REQ.
  task automatic await_ack(input int exp_lat);
    int n;
    logic [33:0] e;
    n = 0;
    @(posedge CLK); #1;
    A = 16'($urandom_range(0, 65535));
    D = 16'($urandom_range(0, 65535));
    while (!ACK && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("ack_rise_latency", n, exp_lat);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 0, 1);
      e = '0;
    end else begin
      e = exp_q.pop_front();
    end
    chk("q", Q, e[31:16]);
    chk("r", R, e[15:0]);
    chk("fdbz", FDBZ, e[33]);
`ifdef DIV_OVF_EN
    chk("ovf", OVF, e[32]);
`endif
    REQ = 1'b0;
    @(posedge CLK); #1;
    chk("ack_fall", ACK, 0);
    chk("q_hold", Q, e[31:16]);
  endtask

  initial begin
    logic [15:0] ra, rd;
    logic        rs;
    int n;
    RST = 1'b0; REQ = 1'b0; SGN = 1'b0; A = '0; D = '0;
    REQ8 = 1'b0; SGN8 = 1'b0; A8 = '0; D8 = '0;
    #12;
    chk("rst_ack", ACK, 0);
    chk("rst_q", Q, 0);
    chk("rst_r", R, 0);
    chk("rst_fdbz", FDBZ, 0);
`ifdef DIV_OVF_EN
    chk("rst_ovf", OVF, 0);
`endif
    @(negedge CLK);
    RST = 1'b1;

    issue(1'b1, 16'd7, 16'd2, {1'b0, 1'b0, 16'd3, 16'd1});
    await_ack(17);
    issue(1'b1, 16'hFFF9, 16'd2, {1'b0, 1'b0, 16'hFFFD, 16'hFFFF});
    await_ack(17);
    issue(1'b1, 16'd7, 16'hFFFE, {1'b0, 1'b0, 16'hFFFD, 16'd1});
    await_ack(17);
    issue(1'b1, 16'd5, 16'd0, {1'b1, 1'b0, 16'd0, 16'd5});
    await_ack(1);
    issue(1'b1, 16'd100, 16'd9, {1'b0, 1'b0, 16'd11, 16'd1});
    await_ack(17);
    issue(1'b1, 16'hFFF0, 16'd0, {1'b1, 1'b0, 16'd0, 16'hFFF0});
    await_ack(1);
    issue(1'b1, 16'h8000, 16'hFFFF, {1'b0, 1'b1, 16'h8000, 16'h0});
    await_ack(17);
    issue(1'b0, 16'h8000, 16'hFFFF, {1'b0, 1'b0, 16'h0, 16'h8000});
    await_ack(17);
    issue(1'b0, 16'hFFFF, 16'h0002, {1'b0, 1'b0, 16'h7FFF, 16'd1});
    await_ack(17);

    // Reset during CALC: abort, then REQ held high across release is re-sampled in IDLE.
    @(negedge CLK);
    SGN = 1'b1; A = 16'd1000; D = 16'd3; REQ = 1'b1;
    @(posedge CLK);
    repeat (5) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("abort_ack", ACK, 0);
    chk("abort_q", Q, 0);
    chk("abort_r", R, 0);
    A = 16'd9; D = 16'd4;
    exp_q.push_back({1'b0, 1'b0, 16'd2, 16'd1});
    @(negedge CLK);
    RST = 1'b1;
    await_ack(17);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = 16'($urandom_range(0, 65535));
      rd = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 15)) : 16'($urandom_range(0, 65535));
      issue(rs, ra, rd, model(rs, ra, rd));
      await_ack(rd == 16'h0 ? 1 : 17);
    end

    @(negedge CLK);
    SGN8 = 1'b1; A8 = 8'h80; D8 = 8'h03; REQ8 = 1'b1;
    n = 0;
    @(posedge CLK); #1;
    while (!ACK8 && n < 100) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("w8_latency", n, 9);
    chk("w8_q", Q8, 8'hD6);
    chk("w8_r", R8, 8'hFE);
    chk("w8_fdbz", FDBZ8, 0);
    REQ8 = 1'b0;
    @(posedge CLK); #1;
    chk("w8_ack_fall", ACK8, 0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_hs_param.md
# div_hs_param

Parametrised iterative integer divider behind a four-phase REQ/ACK handshake, the next generation of the team's fixed 16-bit signed divider.
- Adds: configurable operand width, a per-request signed/unsigned mode and optional overflow flagging.
- Computes truncating quotient and remainder, one quotient bit per clock.
- Sits as a slave co-processor beside the datapath, driven by a requester that holds operands stable while REQ is high.

## Interface
- W, 16, operand/result width in bits (W ≥ 4).
- CW, $clog2(W+1), iteration counter width (derived, do not override).
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low.
- REQ  in  1  request; four-phase handshake with ACK.
- SGN  in  1  1 = two's-complement operands/results, 0 = unsigned.
- A    in  W  dividend.
- D    in  W  divisor.
- ACK  out 1  result valid / handshake acknowledge.
- Q    out W  quotient.
- R    out W  remainder.
- FDBZ out 1  divide-by-zero flag for the current result.
- OVF  out 1  signed overflow flag; present only with DIV_OVF_EN.

## Operation
- States:
  - IDLE: ACK=0; REQ sampled 1 → capture, go to CALC (or DONE if D==0).
  - CALC: one restoring shift/subtract step per edge; counter runs down from W.
  - FIX: applies signs, registers Q/R/flags, sets ACK=1 → DONE.
  - DONE: holds ACK=1 until REQ sampled 0, then ACK=0 → IDLE.
- Capture edge: latch SGN, sign of A, sign of D, |A|, |D| as W-bit unsigned magnitudes. |MIN| = 2^(W-1) fits unsigned. A and D are ignored at all other edges.
- Arithmetic: truncation toward zero. Quotient is negative iff SGN=1 and sign(A)≠sign(D). R carries the sign of A and satisfies A = Q·D + R with |R| < |D|.
- Divide by zero (D==0 at capture): skip CALC/FIX and go directly to DONE. Result is FDBZ=1, Q=0, R=A (raw bits), OVF=0.
- Signed MIN/−1 (SGN=1, A=2^(W-1), D=all-ones): Q=MIN (wraps), R=0.
- Q, R, FDBZ, OVF update only on the edge that raises ACK. They hold the last result through ACK fall and IDLE until the next result.
- REQ dropping during CALC/FIX is a protocol violation. The computation still completes, ACK rises, then falls on the next edge where REQ is sampled 0.
- A new request is accepted only from IDLE, i.e. only after ACK has returned to 0.

## Timing
- Reset (RST=0, async): state=IDLE, counter=0, ACK=0, Q=0, R=0, FDBZ=0, OVF=0. Asserting RST mid-operation aborts immediately with no result; the first edge after release is evaluated in IDLE.
- Latency, normal: capture at edge e0; CALC occupies e1..eW; FIX at e(W+1) sets ACK=1. W=16 → ACK high 17 edges after capture.
- Latency, D==0: ACK=1 at e1.
- ACK falls on the first edge after REQ is sampled 0 in DONE. The earliest next capture is the edge after ACK is seen 0 with REQ=1.
- Minimum full transaction, W=16: 1 capture + 17 + 1 release = 19 cycles plus requester turnaround.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- DIV_OVF_EN defined:
  - OVF port exists.
  - OVF=1 with the result when SGN=1, A=MIN, D=−1; otherwise 0.
  - Q/R values unchanged (Q=MIN, R=0).
- DIV_OVF_EN undefined:
  - No OVF port and no detection logic.
  - The MIN/−1 case still yields Q=MIN, R=0 silently.

## Test plan
- W=16, SGN=1, A=7, D=2 → Q=3, R=1, FDBZ=0, ACK rises 17 edges after capture. Then drop REQ → ACK=0 one edge later.
- SGN=1, A=−7 (0xFFF9), D=2 → Q=−3 (0xFFFD), R=−1 (0xFFFF). Also A=7, D=−2 → Q=−3, R=1.
- SGN=1, A=5, D=0 → FDBZ=1, Q=0, R=5, ACK=1 one edge after capture. The next request, 100/9, gives Q=11, R=1, FDBZ=0.
- SGN=1, A=0x8000, D=0xFFFF → Q=0x8000, R=0. OVF=1 with DIV_OVF_EN; no OVF port without it. With SGN=0, same operands → Q=0, R=0x8000.
- SGN=0, A=0xFFFF, D=0x0002 → Q=0x7FFF, R=1. W=8 build: SGN=1, A=0x80, D=0x03 → Q=0xD6 (−42), R=0xFE (−2).
- Assert RST at CALC cycle 5 → ACK=0 and Q=R=0 immediately. After release, REQ stays high across the release (re-sampled in IDLE) with A=9, D=4 → result Q=2, R=1.
